// File: rtl/count_sched_if.sv
// count_sched_if: request/grant bus between client blocks and the shared run counter.
interface count_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) ();
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] req;
  logic             hold;
  logic [N_REQ-1:0] grant;
  logic [WIDTH-1:0] cnt;
  logic             reached;
  logic             done;
  logic             abort;
  logic [IW-1:0]    owner_id;
  logic             busy;
  modport master (
    output req, hold,
    input  grant, cnt, reached, done, abort, owner_id, busy
  );
  modport slave (
    input  req, hold,
    output grant, cnt, reached, done, abort, owner_id, busy
  );
endinterface

// File: rtl/count_sched.sv
// count_sched: round-robin arbiter lending one 0..MAX_VAL run counter to N_REQ requesters.
module count_sched #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 8
) (
  input logic          clk,
  input logic          rst,
  count_sched_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d, ptr_q, ptr_d, win, win_nxt;
  logic             done_q, done_d, abort_q, abort_d;
  // Descending scan so the bit closest to ptr (smallest wrapped offset) is assigned last.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int s;
    w = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s = int'(p) + i;
      s = (s >= N_REQ) ? s - N_REQ : s;
      w = r[s] ? IW'(s) : w;
    end
    return w;
  endfunction
  always_comb begin
    win     = rr_pick(bus.req, ptr_q);
    win_nxt = (int'(win) == N_REQ - 1) ? '0 : win + IW'(1);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        grant_d = '0;
        if (|bus.req) begin
          state_d = RUN;
          grant_d = N_REQ'(1) << win;
          owner_d = win;
          ptr_d   = win_nxt;
        end
      end
      RUN: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (bus.hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == MAXV) begin
          state_d = FIN;
          grant_d = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      FIN: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end
  assign bus.grant    = grant_q;
  assign bus.cnt      = cnt_q;
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;
  assign bus.owner_id = owner_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.reached  = (state_q == RUN) && (cnt_q == MAXV);
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_done_abort:   assert property (@(posedge clk) disable iff (rst) !(done_q && abort_q));
  a_cnt_range:    assert property (@(posedge clk) disable iff (rst) cnt_q <= MAXV);
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: randomized run plans scored against a run-level model of the scheduler.
module tb_count_sched;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXV = 8;
  typedef struct {
    int owner;
    int abrt;
    int len;
    int end_cnt;
    int gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ptr_m = 0;
  int   next_gap = -1;
  exp_t exp_q[$];
  count_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();
  count_sched #(.N_REQ(N), .WIDTH(W), .MAX_VAL(MAXV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  // mode 0: full run, 1: owner drops req at count p, 2: hold for k cycles at count p
  task automatic run(input logic [N-1:0] mask, input int mode, input int p, input int k);
    int w, len, hk, cm, t;
    logic [N-1:0] ob, r;
    exp_t e;
    w = pick(mask, ptr_m);
    ptr_m = (w + 1) % N;
    ob = '0;
    ob[w] = 1'b1;
    len = (mode == 1) ? p + 1 : MAXV + 1 + ((mode == 2) ? k : 0);
    e.owner = w;
    e.abrt = (mode == 1);
    e.len = len;
    e.end_cnt = (mode == 1) ? p : MAXV;
    e.gap = next_gap;
    exp_q.push_back(e);
    bus.req = mask;
    bus.hold = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.grant == 0 && t < 6);
    if (bus.grant == 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=0 expected=nonzero mask=%b", mask);
      $fatal(1);
    end
    hk = k;
    cm = 0;
    for (int j = 0; j < len; j++) begin
      if (j > 0) @(negedge clk);
      r = N'($urandom);
      bus.req = (mode == 1 && j == p) ? (r & ~ob) : (r | ob);
      bus.hold = (mode == 2 && cm == p && hk > 0);
      if (bus.hold) hk--;
      else cm++;
    end
    @(negedge clk);
    bus.hold = 1'b0;
    bus.req = '0;
    next_gap = (mode == 1) ? 1 : 2;
  endtask
  initial begin
    int len = 0, gap = -1, sgap = -1, prev = 0;
    bit in_run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_run = 0;
        gap = -1;
      end else begin
        chk("busy", bus.busy, bus.grant != 0);
        chk("reached", bus.reached, bus.busy && bus.cnt == MAXV);
        chk("done_abort_excl", bus.done & bus.abort, 0);
        if (bus.grant != 0) begin
          chk("grant_owner", bus.grant, 1 << bus.owner_id);
          if (!in_run) begin
            in_run = 1;
            len = 0;
            sgap = gap;
            chk("run_start_cnt", bus.cnt, 0);
          end else begin
            chk("cnt_step", int'(bus.cnt == prev || bus.cnt == prev + 1), 1);
          end
          prev = bus.cnt;
          len++;
        end else begin
          chk("cnt_idle", bus.cnt, 0);
          if (in_run) begin
            chk("end_pulse", bus.done | bus.abort, 1);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected actual=run_end expected=none owner=%0d", bus.owner_id);
            end else begin
              e = exp_q.pop_front();
              chk("owner_id", bus.owner_id, e.owner);
              chk("abort_kind", bus.abort, e.abrt);
              chk("done_kind", bus.done, 1 - e.abrt);
              chk("grant_len", len, e.len);
              chk("end_cnt", prev, e.end_cnt);
              if (e.gap >= 0) chk("grant_gap", sgap, e.gap);
            end
            in_run = 0;
            gap = 0;
          end else begin
            chk("stray_pulse", bus.done | bus.abort, 0);
          end
          if (gap >= 0) gap++;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    int t;
    bus.req = '0;
    bus.hold = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_abort", bus.abort, 0);
    chk("rst_owner", bus.owner_id, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    run(4'b0001, 0, 0, 0);
    run(4'b0001, 0, 0, 0);
    repeat (5) run(4'b1111, 0, 0, 0);
    run(4'b0100, 0, 0, 0);
    run(4'b0100, 0, 0, 0);
    run(4'b1010, 1, 3, 0);
    run(4'b1111, 2, MAXV, 5);
    run(4'b0001, 1, 0, 0);
    repeat (50) begin
      run(N'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, MAXV), $urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        next_gap = -1;
      end
    end
    bus.req = 4'b0001;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.grant == 0 && t < 6);
    chk("pre_reset_grant", bus.grant, 1);
    repeat (5) @(negedge clk);
    chk("pre_reset_cnt", bus.cnt, 5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_grant", bus.grant, 0);
    chk("midrst_cnt", bus.cnt, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_abort", bus.abort, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    ptr_m = 0;
    next_gap = -1;
    run(4'b1111, 0, 0, 0);
    run(4'b0001, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
